sd_emmc_ddr_data_rx: RTL and testbench

SD_EMMC_DDR_DATA_RX -- requirements
Module: sd_emmc_ddr_data_rx

---
 rtl/sd_emmc_pkg.sv | 26 ++
 rtl/sd_emmc_ddr_data_rx_iddr.sv | 52 +++++
 rtl/sd_emmc_ddr_data_rx.sv | 216 +++++++++++++++++++++
 tb/tb_sd_emmc_ddr_data_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_emmc_pkg.sv
// Shared types and constants for the eMMC DDR data receive path.
// Holds the FSM encoding, CRC16 constants and a one-bit CRC update helper.
package sd_emmc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END_BIT
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int CRC_LEN = 16;
  localparam int DEF_BLOCK_BYTES = 512;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] c,
    input logic        b
  );
    logic fb;
    fb = c[15] ^ b;
    crc16_step = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_emmc_ddr_data_rx_iddr.sv
// 8-lane input DDR cell, same-edge-pipelined: the rise and fall samples
// of one clock period are presented together on the following rising edge.
module IDDR_p #(
  parameter string SR_TYPE = "SYNC"
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] q1,
  output logic [7:0] q2
);

  logic [7:0] rise_q;
  logic [7:0] fall_q;

  if (SR_TYPE == "ASYNC") begin : g_async
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rise_q <= '0;
        q1     <= '0;
        q2     <= '0;
      end else begin
        rise_q <= d;
        q1     <= rise_q;
        q2     <= fall_q;
      end
    end

    always_ff @(negedge clock or posedge reset) begin
      if (reset) fall_q <= '0;
      else       fall_q <= d;
    end
  end else begin : g_sync
    always_ff @(posedge clock) begin
      if (reset) begin
        rise_q <= '0;
        q1     <= '0;
        q2     <= '0;
      end else begin
        rise_q <= d;
        q1     <= rise_q;
        q2     <= fall_q;
      end
    end

    always_ff @(negedge clock) begin
      if (reset) fall_q <= '0;
      else       fall_q <= d;
    end
  end

endmodule

// File: rtl/sd_emmc_ddr_data_rx.sv
// eMMC DDR block receiver: start-bit search with timeout, 4/8-bit data
// unpacking into 16-bit words, per-line per-edge CRC16 check, end-bit check.
module sd_emmc_ddr_data_rx
  import sd_emmc_pkg::*;
#(
  parameter int    BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter string SR_TYPE     = "SYNC"
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dat_in,
  input  logic        bus_width_8,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] timeout_cycles,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic        end_err,
  output logic        timeout_err
);

  localparam logic [23:0] W8_LAST = 24'(BLOCK_BYTES / 2 - 1);
  localparam logic [23:0] W4_LAST = 24'(BLOCK_BYTES - 1);
  localparam logic [23:0] C_LAST  = 24'(CRC_LEN - 1);

  logic [7:0] q1;
  logic [7:0] q2;

  IDDR_p #(
    .SR_TYPE (SR_TYPE)
  ) u_iddr (
    .clock (clock),
    .reset (reset),
    .d     (dat_in),
    .q1    (q1),
    .q2    (q2)
  );

  state_e           state_q, state_d;
  logic             bw8_q, bw8_d;
  logic [23:0]      tmo_q, tmo_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0][15:0] crc_r_q, crc_r_d;
  logic [7:0][15:0] crc_f_q, crc_f_d;
  logic [15:0]      dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             dl_q, dl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d;
  logic             tmo_err_q, tmo_err_d;

  logic [7:0] mask;
  logic [7:0] nib_byte;
  logic       last;

  assign mask = bw8_q ? 8'hFF : 8'h0F;

  always_comb begin
    state_d   = state_q;
    bw8_d     = bw8_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    crc_r_d   = crc_r_q;
    crc_f_d   = crc_f_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    dl_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    tmo_err_d = tmo_err_q;
    nib_byte  = {q1[3:0], q2[3:0]};
    last      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_WAIT_START;
          bw8_d     = bus_width_8;
          tmo_d     = timeout_cycles;
          cnt_d     = '0;
          busy_d    = 1'b1;
          crc_r_d   = '0;
          crc_f_d   = '0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          tmo_err_d = 1'b0;
        end
      end
      S_WAIT_START: begin
        if ((q1 & mask) == 8'h00) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else if ({1'b0, cnt_q} + 25'd1 >= {1'b0, tmo_q}) begin
          state_d   = S_IDLE;
          tmo_err_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_DATA: begin
        for (int i = 0; i < 8; i++) begin
          crc_r_d[i] = crc16_step(crc_r_q[i], q1[i]);
          crc_f_d[i] = crc16_step(crc_f_q[i], q2[i]);
        end
        if (bw8_q) begin
          dout_d = {q1, q2};
          dv_d   = 1'b1;
          last   = (cnt_q == W8_LAST);
        end else begin
          last = (cnt_q == W4_LAST);
          // Even cycles hold the first byte, odd cycles complete the word
          if (!cnt_q[0]) begin
            hi_d = nib_byte;
          end else begin
            dout_d = {hi_q, nib_byte};
            dv_d   = 1'b1;
          end
        end
        dl_d = last;
        if (last) begin
          state_d = S_CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_CRC: begin
        for (int i = 0; i < 8; i++) begin
          if (mask[i] && ((q1[i] != crc_r_q[i][15]) ||
                          (q2[i] != crc_f_q[i][15])))
            crc_err_d = 1'b1;
          crc_r_d[i] = {crc_r_q[i][14:0], 1'b0};
          crc_f_d[i] = {crc_f_q[i][14:0], 1'b0};
        end
        if (cnt_q == C_LAST) begin
          state_d = S_END_BIT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_END_BIT: begin
        if ((q1 | ~mask) != 8'hFF) end_err_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      dv_d    = 1'b0;
      dl_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bw8_q     <= 1'b0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      crc_r_q   <= '0;
      crc_f_q   <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      dl_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bw8_q     <= bw8_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      crc_r_q   <= crc_r_d;
      crc_f_q   <= crc_f_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      dl_q      <= dl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign data_last   = dl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign crc_err     = crc_err_q;
  assign end_err     = end_err_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sd_emmc_ddr_data_rx.sv
// Scoreboard bench: the driver queues expected words and done status,
// a negedge monitor pops and compares whatever the receiver presents.
module tb_sd_emmc_ddr_data_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  dat_in = 8'hFF;
  logic        bus_width_8 = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] timeout_cycles = 24'd1000;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_last;
  logic        busy;
  logic        done;
  logic        crc_err;
  logic        end_err;
  logic        timeout_err;

  sd_emmc_ddr_data_rx #(
    .BLOCK_BYTES (512),
    .SR_TYPE     ("SYNC")
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dat_in         (dat_in),
    .bus_width_8    (bus_width_8),
    .start          (start),
    .abort          (abort),
    .timeout_cycles (timeout_cycles),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_last      (data_last),
    .busy           (busy),
    .done           (done),
    .crc_err        (crc_err),
    .end_err        (end_err),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_w[$];
  logic [2:0]  exp_s[$];
  logic [16:0] mw;
  logic [2:0]  ms;
  bit          mode4 = 1'b0;
  bit          prev_dv = 1'b0;
  logic [7:0]  data [512];

  always @(negedge clock) begin
    if (data_valid) begin
      n_vec++;
      if (exp_w.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word got %h want none", data_out);
      end else begin
        mw = exp_w.pop_front();
        if ({data_last, data_out} !== mw) begin
          n_err++;
          $display("FAIL word got last=%b data=%h want last=%b data=%h",
                   data_last, data_out, mw[16], mw[15:0]);
        end
      end
      if (mode4) begin
        n_vec++;
        if (prev_dv) begin
          n_err++;
          $display("FAIL nibble_spacing got back-to-back valid want gap");
        end
      end
    end
    if (done) begin
      n_vec++;
      if (exp_s.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done got crc/end/tmo=%b%b%b want no done",
                 crc_err, end_err, timeout_err);
      end else begin
        ms = exp_s.pop_front();
        if ({crc_err, end_err, timeout_err} !== ms) begin
          n_err++;
          $display("FAIL status got crc/end/tmo=%b%b%b want %b",
                   crc_err, end_err, timeout_err, ms);
        end
      end
    end
    prev_dv = data_valid;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic send_pair(input logic [7:0] r, input logic [7:0] f,
                           input bit st, input bit ab, input bit rs);
    dat_in = r;
    start  = st;
    abort  = ab;
    reset  = rs;
    @(posedge clock);
    #2;
    dat_in = f;
    start  = 1'b0;
    abort  = 1'b0;
    reset  = 1'b0;
    @(negedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_pair(8'hFF, 8'hFF, 0, 0, 0);
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c,
                                          input logic b);
    logic fb;
    fb = c[15] ^ b;
    c = c << 1;
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  task automatic run_block(input bit bw8, input int cut_at,
                           input bit cut_rst, input bit crc_flip,
                           input bit end_bad);
    logic [7:0]  pr[$];
    logic [7:0]  pf[$];
    logic [15:0] cr[8];
    logic [15:0] cf[8];
    logic [7:0]  r;
    logic [7:0]  f;
    int n;
    int nw;
    n = bw8 ? 256 : 512;
    for (int k = 0; k < n; k++) begin
      if (bw8) begin
        pr.push_back(data[2*k]);
        pf.push_back(data[2*k+1]);
      end else begin
        pr.push_back({4'hF, data[k][7:4]});
        pf.push_back({4'hF, data[k][3:0]});
      end
    end
    for (int i = 0; i < 8; i++) begin
      cr[i] = 16'h0;
      cf[i] = 16'h0;
      for (int k = 0; k < n; k++) begin
        cr[i] = crc_bit(cr[i], pr[k][i]);
        cf[i] = crc_bit(cf[i], pf[k][i]);
      end
    end
    nw = (cut_at >= 0) ? cut_at - 2 : 256;
    for (int w = 0; w < nw; w++)
      exp_w.push_back({(cut_at < 0 && w == 255), data[2*w], data[2*w+1]});
    if (cut_at < 0) exp_s.push_back({crc_flip, end_bad, 1'b0});
    bus_width_8    = bw8;
    timeout_cycles = 24'd1000;
    mode4          = !bw8;
    send_pair(8'hFF, 8'hFF, 1, 0, 0);
    chk("busy_after_arm", {31'd0, busy}, 32'd1);
    idle(2);
    send_pair(bw8 ? 8'h00 : 8'hF0, bw8 ? 8'h00 : 8'hF0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      send_pair(pr[k], pf[k], k == 10, cut_at == k && !cut_rst,
                cut_at == k && cut_rst);
      if (cut_at == k) begin
        if (cut_rst)
          chk("reset_outputs",
              {9'd0, data_out, data_valid, data_last, busy, done,
               crc_err, end_err, timeout_err}, 32'd0);
        else
          chk("abort_busy", {31'd0, busy}, 32'd0);
        idle(4);
        mode4 = 1'b0;
        return;
      end
    end
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 8; i++) begin
        r[i] = cr[i][15-j];
        f[i] = cf[i][15-j];
      end
      if (!bw8) begin
        r[7:4] = 4'hF;
        f[7:4] = 4'hF;
      end
      if (crc_flip && j == 5) f[3] = ~f[3];
      send_pair(r, f, 0, 0, 0);
    end
    send_pair(end_bad ? 8'hFE : 8'hFF, 8'hFF, 0, 0, 0);
    idle(3);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    mode4 = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 512; i++) data[i] = 8'(i);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) send_pair(8'hFF, 8'hFF, 0, 0, 1);
    chk("reset_state",
        {9'd0, data_out, data_valid, data_last, busy, done,
         crc_err, end_err, timeout_err}, 32'd0);
    idle(3);

    fill_ramp();
    run_block(1, -1, 0, 0, 0);

    for (int i = 0; i < 512; i++) data[i] = 8'hA5;
    run_block(0, -1, 0, 0, 0);

    fill_ramp();
    run_block(1, -1, 0, 1, 0);

    exp_s.push_back(3'b001);
    bus_width_8    = 1'b1;
    timeout_cycles = 24'd10;
    send_pair(8'hFF, 8'hFF, 1, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      send_pair(8'hFF, 8'hFF, 0, 0, 0);
      if (c < 10) begin
        chk("tmo_early_done", {31'd0, done}, 32'd0);
      end else begin
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
      end
    end
    idle(3);

    run_block(1, -1, 0, 0, 1);

    run_block(1, 102, 0, 0, 0);

    send_pair(8'hFF, 8'hFF, 1, 1, 0);
    chk("abort_over_start", {31'd0, busy}, 32'd0);
    idle(3);

    run_block(1, -1, 0, 0, 0);

    run_block(1, 50, 1, 0, 0);

    run_block(1, -1, 0, 0, 0);

    idle(5);
    chk("leftover_words", exp_w.size(), 32'd0);
    chk("leftover_status", exp_s.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
